// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and defaults for the serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor cell: d = a - b - bin
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when the minuend bit is 0 and b is 1, or bits are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin_in, one bit per clock, LSB first
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] sd;
  logic [WIDTH-1:0] sd_ext;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             cell_d, cell_bout;
  logic             last_bit;
  logic             busy_nx, done_nx;

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // sd holds only the upper WIDTH-1 result bits; the new bit completes the word.
  assign sd_ext   = {cell_d, sd};
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin_in;
            cnt <= '0;
            sd  <= '0;
          end
        end
        SHIFT: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          sd  <= sd_ext[WIDTH-1:1];
          br  <= cell_bout;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            diff       <= sd_ext;
            borrow_out <= cell_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       bin8, bin2;
  logic       busy8, done8, bo8;
  logic       busy2, done2, bo2;
  logic [7:0] diff8;
  logic [1:0] diff2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin_in(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] exp_d, input logic exp_bo);
    logic [7:0] held_d;
    logic       held_b;
    logic       hold_ok;
    int         n;
    held_d  = diff8;
    held_b  = bo8;
    hold_ok = 1'b1;
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; bin8 = ~bin;
    chk("busy_rise", busy8, 1);
    n = 1;
    while (!done8 && n < 30) begin
      if (diff8 !== held_d || bo8 !== held_b) hold_ok = 1'b0;
      step();
      n++;
    end
    chk("latency8", n, 9);
    chk("hold_in_shift", hold_ok, 1);
    chk("diff8", diff8, exp_d);
    chk("borrow8", bo8, exp_bo);
    chk("busy_at_done", busy8, 1);
    step();
    chk("done_width8", done8, 0);
    chk("busy_fall", busy8, 0);
    chk("diff_hold_idle", diff8, exp_d);
  endtask

  task automatic run2(input int idx);
    logic [2:0] exp;
    int         n;
    a2   = 2'(idx >> 3);
    b2   = 2'(idx >> 1);
    bin2 = idx[0];
    exp  = {1'b0, a2} - {1'b0, b2} - {2'b00, bin2};
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 20) begin
      step();
      n++;
    end
    chk("latency2", n, 3);
    chk("diff2", diff2, exp[1:0]);
    chk("borrow2", bo2, exp[2]);
    step();
    chk("done_width2", done2, 0);
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0;
    start8 = 1'b0; start2 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    a2 = 2'b00; b2 = 2'b00; bin2 = 1'b0;
    step();
    step();
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", bo8, 0);
    chk("rst_busy2", busy2, 0);
    rst_n = 1'b1;
    step();

    run8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run8(8'h80, 8'h80, 1'b1, 8'hFF, 1'b1);

    // start held high; operands changed after acceptance
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
    n = 1;
    while (!done8 && n < 30) begin step(); n++; end
    chk("held_latency", n, 9);
    chk("held_diff1", diff8, 8'h23);
    chk("held_borrow1", bo8, 0);
    step();
    n = 1;
    while (!done8 && n < 30) begin step(); n++; end
    chk("held_period", n, 10);
    chk("held_diff2", diff8, 8'h54);
    chk("held_borrow2", bo8, 0);
    start8 = 1'b0;
    step();
    chk("held_idle", busy8, 0);

    // reset at SHIFT bit 4
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", busy8, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_diff", diff8, 0);
    chk("mid_rst_done", done8, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 || busy8) pulses++;
    end
    chk("no_done_after_rst", pulses, 0);
    run8(8'h0F, 8'h0E, 1'b0, 8'h01, 1'b0);

    // reset dominates start
    rst_n = 1'b0; start8 = 1'b1;
    step();
    rst_n = 1'b1; start8 = 1'b0;
    chk("rst_wins_busy", busy8, 0);
    step();
    chk("rst_wins_idle", busy8, 0);
    chk("rst_wins_diff", diff8, 0);

    for (int i = 0; i < 32; i++) run2(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
